fpmul_seq_ctrl: RTL and testbench

//  Sequencing FSM for the iterative (shift-add) single-precision FP multiplier datapath.

---
 rtl/fpmul_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fpmul_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_seq_ctrl.sv
// fpmul_seq_ctrl
// Sequencing FSM for an iterative shift-add single-precision FP multiplier.
// Each Start accepted in IDLE walks the datapath through:
//   LOAD -> CHECK -> MUL x MANT_W -> NORM -> ROUND -> POSTNORM -> DONE
// A special operand (zero/Inf/NaN) takes the short path:
//   LOAD -> CHECK -> SPECIAL -> DONE
// The iteration counter lives here and only advances in MUL.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   Reset      synchronous active-high reset, forces IDLE
//   Start      operation request, sampled only in IDLE
//   SpecialOp  special-operand flag, sampled in CHECK
//   MulBit     multiplier LSB, gates AddEn during MUL
//   ProdMsb    product MSB, gates NormShift/ExpInc during NORM
//   MantOvf    rounded-mantissa carry, gates NormShift/ExpInc during POSTNORM
//   LoadOps, ExpAdd, AddEn, ShiftEn, NormShift, ExpInc, RoundEn, BypassSel
//              datapath strobes
//   Busy       high in every state except IDLE
//   Done       one-cycle completion pulse
//   IterCnt    current shift-add iteration index
module fpmul_seq_ctrl #(
  parameter int MANT_W = 24,
  parameter int CNT_W  = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             SpecialOp,
  input  logic             MulBit,
  input  logic             ProdMsb,
  input  logic             MantOvf,
  output logic             LoadOps,
  output logic             ExpAdd,
  output logic             AddEn,
  output logic             ShiftEn,
  output logic             NormShift,
  output logic             ExpInc,
  output logic             RoundEn,
  output logic             BypassSel,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] IterCnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_POSTNORM,
    S_SPECIAL,
    S_DONE
  } state_t;

  // Moore strobes, registered alongside the state so they always equal
  // decode(state_reg). norm_ph/post_ph are phase flags that the
  // input-gated outputs are built from.
  typedef struct packed {
    logic load_ops;
    logic exp_add;
    logic shift_en;
    logic norm_ph;
    logic post_ph;
    logic round_en;
    logic bypass_sel;
    logic busy;
    logic done;
  } strobe_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MANT_W - 1);

  function automatic strobe_t decode(input state_t s);
    strobe_t o;
    o            = '0;
    o.load_ops   = (s == S_LOAD);
    o.exp_add    = (s == S_CHECK);
    o.shift_en   = (s == S_MUL);
    o.norm_ph    = (s == S_NORM);
    o.post_ph    = (s == S_POSTNORM);
    o.round_en   = (s == S_ROUND);
    o.bypass_sel = (s == S_SPECIAL);
    o.busy       = (s != S_IDLE);
    o.done       = (s == S_DONE);
    return o;
  endfunction

  state_t           state_reg;
  strobe_t          strobe_reg;
  logic [CNT_W-1:0] iter_reg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg  <= S_IDLE;
      strobe_reg <= '0;
      iter_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Start) begin
            state_reg  <= S_LOAD;
            strobe_reg <= decode(S_LOAD);
          end
        end
        S_LOAD: begin
          state_reg  <= S_CHECK;
          strobe_reg <= decode(S_CHECK);
        end
        S_CHECK: begin
          iter_reg <= '0;
          if (SpecialOp) begin
            state_reg  <= S_SPECIAL;
            strobe_reg <= decode(S_SPECIAL);
          end else begin
            state_reg  <= S_MUL;
            strobe_reg <= decode(S_MUL);
          end
        end
        S_MUL: begin
          // Leave on the last index and hold it there, so the counter
          // never wraps and MUL lasts exactly MANT_W cycles.
          if (iter_reg == LAST_ITER) begin
            state_reg  <= S_NORM;
            strobe_reg <= decode(S_NORM);
          end else begin
            iter_reg <= iter_reg + 1'b1;
          end
        end
        S_NORM: begin
          state_reg  <= S_ROUND;
          strobe_reg <= decode(S_ROUND);
        end
        S_ROUND: begin
          state_reg  <= S_POSTNORM;
          strobe_reg <= decode(S_POSTNORM);
        end
        S_POSTNORM: begin
          state_reg  <= S_DONE;
          strobe_reg <= decode(S_DONE);
        end
        S_SPECIAL: begin
          state_reg  <= S_DONE;
          strobe_reg <= decode(S_DONE);
        end
        S_DONE: begin
          state_reg  <= S_IDLE;
          strobe_reg <= decode(S_IDLE);
        end
        default: begin
          state_reg  <= S_IDLE;
          strobe_reg <= '0;
        end
      endcase
    end
  end

  assign LoadOps   = strobe_reg.load_ops;
  assign ExpAdd    = strobe_reg.exp_add;
  assign ShiftEn   = strobe_reg.shift_en;
  assign RoundEn   = strobe_reg.round_en;
  assign BypassSel = strobe_reg.bypass_sel;
  assign Busy      = strobe_reg.busy;
  assign Done      = strobe_reg.done;
  assign IterCnt   = iter_reg;

  // Same-cycle gating by datapath status bits.
  assign AddEn     = strobe_reg.shift_en & MulBit;
  assign NormShift = (strobe_reg.norm_ph & ProdMsb) | (strobe_reg.post_ph & MantOvf);
  assign ExpInc    = NormShift;

endmodule

// File: tb/tb_fpmul_seq_ctrl.sv
// Directed bench for fpmul_seq_ctrl. Cycle index k=1 is the cycle right
// after the edge that samples Start; outputs are sampled on the falling edge.
module tb_fpmul_seq_ctrl;

  logic       clk;
  logic       Reset, Start, SpecialOp, MulBit, ProdMsb, MantOvf;
  logic       LoadOps, ExpAdd, AddEn, ShiftEn, NormShift, ExpInc;
  logic       RoundEn, BypassSel, Busy, Done;
  logic [4:0] IterCnt;

  int checks   = 0;
  int failures = 0;

  // Per-cycle record of one operation, bit k = value in cycle k.
  logic [63:0] rec_ld, rec_ea, rec_sh, rec_ad, rec_ns, rec_ei, rec_rd, rec_bp, rec_dn, rec_bz;
  logic [4:0]  rec_it [0:63];
  int          done_k;

  fpmul_seq_ctrl #(.MANT_W(24), .CNT_W(5)) dut (
    .CLK(clk), .Reset(Reset), .Start(Start), .SpecialOp(SpecialOp),
    .MulBit(MulBit), .ProdMsb(ProdMsb), .MantOvf(MantOvf),
    .LoadOps(LoadOps), .ExpAdd(ExpAdd), .AddEn(AddEn), .ShiftEn(ShiftEn),
    .NormShift(NormShift), .ExpInc(ExpInc), .RoundEn(RoundEn),
    .BypassSel(BypassSel), .Busy(Busy), .Done(Done), .IterCnt(IterCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mask(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [9:0] all_outs();
    return {LoadOps, ExpAdd, AddEn, ShiftEn, NormShift, ExpInc, RoundEn, BypassSel, Busy, Done};
  endfunction

  // Issue one Start and record every output until Done (bounded).
  task automatic run_op(input logic sp, input logic mb, input logic pm, input logic mo,
                        input bit repulse);
    rec_ld = '0; rec_ea = '0; rec_sh = '0; rec_ad = '0; rec_ns = '0;
    rec_ei = '0; rec_rd = '0; rec_bp = '0; rec_dn = '0; rec_bz = '0;
    done_k = 0;
    @(negedge clk);
    Start = 1'b1; SpecialOp = sp; MulBit = mb; ProdMsb = pm; MantOvf = mo;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      Start = (repulse && k == 9) ? 1'b1 : 1'b0;
      rec_ld[k] = LoadOps;  rec_ea[k] = ExpAdd;    rec_sh[k] = ShiftEn;
      rec_ad[k] = AddEn;    rec_ns[k] = NormShift; rec_ei[k] = ExpInc;
      rec_rd[k] = RoundEn;  rec_bp[k] = BypassSel; rec_dn[k] = Done;
      rec_bz[k] = Busy;     rec_it[k] = IterCnt;
      if (Done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 10'b0) begin
      failures++;
      $display("FAIL reset_outs: got %b expected %b", all_outs(), 10'b0);
    end
    checks++;
    if (IterCnt !== 5'd0) begin
      failures++;
      $display("FAIL reset_itercnt: got %0d expected 0", IterCnt);
    end
    Reset = 1'b0; Start = 1'b0;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b expected 0", Busy);
    end
  endtask

  task automatic test_normal();
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("normal op: done at cycle %0d", done_k);
    checks++;
    if (done_k !== 30) begin failures++; $display("FAIL normal_done_k: got %0d expected 30", done_k); end
    checks++;
    if (rec_ld !== mask(1, 1)) begin failures++; $display("FAIL normal_loadops: got %h expected %h", rec_ld, mask(1, 1)); end
    checks++;
    if (rec_ea !== mask(2, 2)) begin failures++; $display("FAIL normal_expadd: got %h expected %h", rec_ea, mask(2, 2)); end
    checks++;
    if (rec_sh !== mask(3, 26)) begin failures++; $display("FAIL normal_shiften: got %h expected %h", rec_sh, mask(3, 26)); end
    checks++;
    if (rec_ad !== mask(3, 26)) begin failures++; $display("FAIL normal_adden: got %h expected %h", rec_ad, mask(3, 26)); end
    checks++;
    if (rec_rd !== mask(28, 28)) begin failures++; $display("FAIL normal_rounden: got %h expected %h", rec_rd, mask(28, 28)); end
    checks++;
    if ((rec_ns | rec_ei | rec_bp) !== 64'd0) begin
      failures++; $display("FAIL normal_no_norm_bypass: got %h expected 0", rec_ns | rec_ei | rec_bp);
    end
    checks++;
    if (rec_bz !== mask(1, 30)) begin failures++; $display("FAIL normal_busy: got %h expected %h", rec_bz, mask(1, 30)); end
    checks++;
    if (rec_it[3] !== 5'd0 || rec_it[26] !== 5'd23 || rec_it[27] !== 5'd23) begin
      failures++;
      $display("FAIL normal_itercnt: got %0d/%0d/%0d expected 0/23/23", rec_it[3], rec_it[26], rec_it[27]);
    end
  endtask

  task automatic test_norm_round_ovf();
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    $display("norm/ovf op: done at cycle %0d", done_k);
    checks++;
    if (done_k !== 30) begin failures++; $display("FAIL normovf_done_k: got %0d expected 30", done_k); end
    checks++;
    if (rec_ns !== (mask(27, 27) | mask(29, 29))) begin
      failures++; $display("FAIL normovf_normshift: got %h expected %h", rec_ns, mask(27, 27) | mask(29, 29));
    end
    checks++;
    if (rec_ei !== (mask(27, 27) | mask(29, 29))) begin
      failures++; $display("FAIL normovf_expinc: got %h expected %h", rec_ei, mask(27, 27) | mask(29, 29));
    end
    checks++;
    if (rec_ad !== 64'd0) begin failures++; $display("FAIL normovf_adden_gated: got %h expected 0", rec_ad); end
    checks++;
    if (rec_sh !== mask(3, 26)) begin failures++; $display("FAIL normovf_shiften: got %h expected %h", rec_sh, mask(3, 26)); end
  endtask

  task automatic test_special();
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    $display("special op: done at cycle %0d", done_k);
    checks++;
    if (done_k !== 4) begin failures++; $display("FAIL special_done_k: got %0d expected 4", done_k); end
    checks++;
    if (rec_bp !== mask(3, 3)) begin failures++; $display("FAIL special_bypass: got %h expected %h", rec_bp, mask(3, 3)); end
    checks++;
    if ((rec_sh | rec_ad | rec_rd | rec_ns | rec_ei) !== 64'd0) begin
      failures++; $display("FAIL special_no_mul: got %h expected 0", rec_sh | rec_ad | rec_rd | rec_ns | rec_ei);
    end
    checks++;
    if (rec_ea !== mask(2, 2)) begin failures++; $display("FAIL special_expadd: got %h expected %h", rec_ea, mask(2, 2)); end
    SpecialOp = 1'b0;
  endtask

  task automatic test_back_to_back();
    int dk;
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    $display("repulse op: done at cycle %0d", done_k);
    checks++;
    if (done_k !== 30) begin failures++; $display("FAIL b2b_done_k: got %0d expected 30", done_k); end
    checks++;
    if (rec_ld !== mask(1, 1)) begin failures++; $display("FAIL b2b_single_load: got %h expected %h", rec_ld, mask(1, 1)); end
    // Start during DONE: must be ignored.
    Start = 1'b1;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || LoadOps !== 1'b0) begin
      failures++; $display("FAIL b2b_start_in_done: got busy=%b load=%b expected 0/0", Busy, LoadOps);
    end
    // Start held into the cycle after Done: accepted.
    @(negedge clk);
    Start = 1'b0;
    checks++;
    if (LoadOps !== 1'b1 || Busy !== 1'b1) begin
      failures++; $display("FAIL b2b_next_load: got load=%b busy=%b expected 1/1", LoadOps, Busy);
    end
    dk = 0;
    for (int k = 2; k <= 60; k++) begin
      @(negedge clk);
      if (Done) begin
        dk = k;
        break;
      end
    end
    $display("second op: done at cycle %0d", dk);
    checks++;
    if (dk !== 30) begin failures++; $display("FAIL b2b_second_done: got %0d expected 30", dk); end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    Start = 1'b1; SpecialOp = 1'b0; MulBit = 1'b1; ProdMsb = 1'b0; MantOvf = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (IterCnt !== 5'd12 || ShiftEn !== 1'b1) begin
      failures++; $display("FAIL midreset_pre: got cnt=%0d shift=%b expected 12/1", IterCnt, ShiftEn);
    end
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    checks++;
    if (all_outs() !== 10'b0 || IterCnt !== 5'd0) begin
      failures++; $display("FAIL midreset_post: got outs=%b cnt=%0d expected 0/0", all_outs(), IterCnt);
    end
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("post-reset op: done at cycle %0d", done_k);
    checks++;
    if (done_k !== 30) begin failures++; $display("FAIL midreset_done_k: got %0d expected 30", done_k); end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; SpecialOp = 1'b0;
    MulBit = 1'b0; ProdMsb = 1'b0; MantOvf = 1'b0;
    test_reset();
    test_normal();
    test_norm_round_ovf();
    test_special();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
